// File: rtl/calculadora_multicanal.sv
// Multi-accumulator calculator: 1-cycle ALU ops, WIDTH-cycle shift-add MUL (in_ready low while busy).
// Optional clamping arithmetic when SATURATE_EN is defined; default build wraps modulo 2^WIDTH.
module calculadora_multicanal #(
  parameter int WIDTH = 8,
  parameter int N_ACC = 4,
  parameter int SEL_W = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic [3:0]       codigo,
  input  logic [SEL_W-1:0] sel_acc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] saida,
  output logic             out_valid,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [SEL_W:0] N_ACC_L  = N_ACC[SEL_W:0];
  localparam logic [CW-1:0]  CNT_INIT = WIDTH[CW-1:0];
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_SHOW_IN  = 4'd0;
  localparam logic [3:0] OP_ADD      = 4'd1;
  localparam logic [3:0] OP_SUB      = 4'd2;
  localparam logic [3:0] OP_SHOW_ACC = 4'd3;
  localparam logic [3:0] OP_MUL      = 4'd4;
  localparam logic [3:0] OP_CLR      = 4'd5;
  localparam logic [3:0] OP_LOAD     = 4'd6;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc [N_ACC];
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mplier;
  logic [SEL_W-1:0]   idx;
  logic [CW-1:0]      count;

  logic               accept;
  logic               sel_ok;
  logic [WIDTH-1:0]   a_val;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_next;
  logic               mul_ovf;
  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;
  logic [WIDTH-1:0]   mul_res;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign sel_ok   = ({1'b0, sel_acc} < N_ACC_L);
  assign a_val    = sel_ok ? acc[sel_acc] : '0;

  // mcand is kept pre-shifted, so each step adds it directly when the multiplier LSB is set
  always_comb begin
    sum       = {1'b0, a_val} + {1'b0, entrada};
    diff      = {1'b0, a_val} - {1'b0, entrada};
    prod_next = product + (mplier[0] ? mcand : '0);
    mul_ovf   = |prod_next[2*WIDTH-1:WIDTH];
`ifdef SATURATE_EN
    add_res   = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
    sub_res   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    mul_res   = mul_ovf     ? '1 : prod_next[WIDTH-1:0];
`else
    add_res   = sum[WIDTH-1:0];
    sub_res   = diff[WIDTH-1:0];
    mul_res   = prod_next[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      for (int i = 0; i < N_ACC; i++) acc[i] <= '0;
      saida     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      mcand     <= '0;
      product   <= '0;
      mplier    <= '0;
      idx       <= '0;
      count     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && sel_ok) begin
            case (codigo)
              OP_SHOW_IN: begin
                saida     <= entrada;
                out_valid <= 1'b1;
              end
              OP_ADD: begin
                acc[sel_acc] <= add_res;
                saida        <= '0;
                overflow     <= sum[WIDTH];
                zero         <= (add_res == '0);
              end
              OP_SUB: begin
                acc[sel_acc] <= sub_res;
                saida        <= '0;
                overflow     <= diff[WIDTH];
                zero         <= (sub_res == '0);
              end
              OP_SHOW_ACC: begin
                saida     <= a_val;
                out_valid <= 1'b1;
              end
              OP_MUL: begin
                mcand   <= {{WIDTH{1'b0}}, a_val};
                mplier  <= entrada;
                idx     <= sel_acc;
                product <= '0;
                count   <= CNT_INIT;
                busy    <= 1'b1;
                state   <= MUL;
              end
              OP_CLR: begin
                acc[sel_acc] <= '0;
                zero         <= 1'b1;
                overflow     <= 1'b0;
              end
              OP_LOAD: begin
                acc[sel_acc] <= entrada;
                zero         <= (entrada == '0);
                overflow     <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          product <= prod_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            acc[idx] <= mul_res;
            overflow <= mul_ovf;
            zero     <= (mul_res == '0);
            saida    <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calculadora_multicanal.sv
// Scoreboarded random + directed bench for calculadora_multicanal against an arithmetic reference model.
module tb_calculadora_multicanal;
  localparam int W    = 8;
  localparam int N    = 4;
  localparam longint MAXV = (64'd1 << W) - 1;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] entrada;
  logic [3:0]   codigo;
  logic [1:0]   sel_acc;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] saida;
  logic         out_valid;
  logic         overflow;
  logic         zero;
  logic         busy;

  calculadora_multicanal #(.WIDTH(W), .N_ACC(N)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .codigo(codigo), .sel_acc(sel_acc),
    .in_valid(in_valid), .in_ready(in_ready), .saida(saida), .out_valid(out_valid),
    .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v;
    bit     ov;
    bit     z;
  } exp_t;

  exp_t   sb[$];
  longint macc [N];
  bit     mov;
  bit     mz;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) macc[i] = 0;
    mov = 1'b0;
    mz  = 1'b0;
  endfunction

  // Reference semantics written straight from the arithmetic rules
  function automatic void model_apply(input int op, input int s, input longint e);
    longint r;
    exp_t   x;
    case (op)
      0: begin x.v = e; x.ov = mov; x.z = mz; sb.push_back(x); end
      1: begin
        r = macc[s] + e;
        mov = (r > MAXV);
        if (mov) r = SAT ? MAXV : r - (MAXV + 1);
        macc[s] = r; mz = (r == 0);
      end
      2: begin
        r = macc[s] - e;
        mov = (e > macc[s]);
        if (mov) r = SAT ? 0 : r + (MAXV + 1);
        macc[s] = r; mz = (r == 0);
      end
      3: begin x.v = macc[s]; x.ov = mov; x.z = mz; sb.push_back(x); end
      4: begin
        r = macc[s] * e;
        mov = (r > MAXV);
        if (mov) r = SAT ? MAXV : r % (MAXV + 1);
        macc[s] = r; mz = (r == 0);
      end
      5: begin macc[s] = 0; mz = 1'b1; mov = 1'b0; end
      6: begin macc[s] = e; mz = (e == 0); mov = 1'b0; end
      default: ;
    endcase
  endfunction

  task automatic issue(input int op, input int s, input int e);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    codigo   = 4'(op);
    sel_acc  = 2'(s);
    entrada  = W'(e);
    in_valid = 1'b1;
    @(posedge clk);
    model_apply(op, s, e);
    #1 in_valid = 1'b0;
  endtask

  // Issue MUL, measure the not-ready and busy windows, optionally spam ADD 1 to acc3 meanwhile
  task automatic mul_timed(input int s, input int e, input bit spam);
    int lo = 0;
    int bz = 0;
    issue(4, s, e);
    while (!in_ready && lo < 100) begin
      lo++;
      if (busy) bz++;
      if (spam) begin
        codigo = 4'd1; sel_acc = 2'd3; entrada = 8'd1; in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("mul_in_ready_low_cycles", lo, W);
    chk("mul_busy_cycles", bz, W);
    chk("mul_busy_after", busy, 0);
    chk("mul_saida_after", saida, 0);
    chk("mul_overflow_after", overflow, mov);
    chk("mul_zero_after", zero, mz);
  endtask

  task automatic show_all();
    for (int i = 0; i < N; i++) issue(3, i, $urandom_range(0, 255));
  endtask

  initial begin
    exp_t got;
    rst = 1'b0; entrada = '0; codigo = '0; sel_acc = '0; in_valid = 1'b0;
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (rst && out_valid) begin
          if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
          else begin
            got = sb.pop_front();
            chk("sb_saida", saida, got.v);
            chk("sb_overflow", overflow, got.ov);
            chk("sb_zero", zero, got.z);
          end
        end
      end
      begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
      end
    join_none

    // Reset held with random activity on the inputs
    repeat (6) begin
      @(negedge clk);
      entrada = W'($urandom); codigo = 4'($urandom); sel_acc = 2'($urandom); in_valid = 1'b1;
    end
    chk("rst_saida", saida, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    show_all();

    // Add carry, then subtract back toward zero
    issue(6, 0, 200);
    issue(1, 0, 100);
    issue(3, 0, 0);
    issue(2, 0, 44);
    issue(3, 0, 0);

    // Subtract borrow, neighbours untouched
    issue(6, 1, 5);
    issue(2, 1, 10);
    show_all();

    // Multiply, then overflowing multiply with traffic during the busy window
    issue(6, 2, 13);
    mul_timed(2, 11, 1'b0);
    issue(3, 2, 0);
    mul_timed(2, 2, 1'b1);
    issue(3, 2, 0);
    issue(3, 3, 0);

    // Idle cycles with garbage on the inputs must change nothing
    repeat (5) begin
      @(negedge clk);
      entrada = W'($urandom); codigo = 4'($urandom); sel_acc = 2'($urandom);
    end
    show_all();

    // Random operation stream, including unused opcodes and back-to-back issue
    for (int k = 0; k < 300; k++) begin
      int op;
      int r;
      r  = $urandom_range(0, 19);
      op = (r < 9) ? r : ((r < 12) ? 3 : ((r < 15) ? 1 : ((r < 17) ? 2 : 4)));
      if (op == 4) mul_timed($urandom_range(0, N - 1), $urandom_range(0, 255), $urandom_range(0, 1) == 1);
      else issue(op, $urandom_range(0, N - 1), (r % 5 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255));
    end
    show_all();

    // Reset in the middle of a multiply
    issue(6, 2, 77);
    issue(4, 2, 3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midmul_busy", busy, 0);
    chk("midmul_in_ready", in_ready, 1);
    chk("midmul_saida", saida, 0);
    chk("midmul_overflow", overflow, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    chk("post_rst_ready", in_ready, 1);
    issue(1, 0, 9);
    show_all();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
